// File: rtl/output_interface_pkg.sv
// Shared widths and packet layout for the result output path.
// Packet order is {res, mode, data} with data in the LSBs, matching the op packet.
package output_interface_pkg;

   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_NUM_MODES      = 3;
   localparam int DEF_RES_WIDTH      = 4;
   localparam int DEF_OUT_FIFO_DEPTH = 8;
   localparam int DEF_PKT_WIDTH      = DEF_DATA_WIDTH + DEF_NUM_MODES + DEF_RES_WIDTH;

   localparam int LEVEL_WIDTH = 4;
   localparam int TX_WIDTH    = 16;

   typedef struct packed {
      logic [DEF_RES_WIDTH-1:0]  res;
      logic [DEF_NUM_MODES-1:0]  mode;
      logic [DEF_DATA_WIDTH-1:0] data;
   } pkt_t;

endpackage

// File: rtl/output_fifo.sv
// Result packet FIFO: power-of-two depth, registered occupancy, guarded push/pop.
module output_fifo
   import output_interface_pkg::*;
#(
   parameter int WIDTH = DEF_PKT_WIDTH,
   parameter int DEPTH = DEF_OUT_FIFO_DEPTH,
   localparam int LW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // full/empty come from the registered level only, so guards never see a same-cycle pop
   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/output_interface.sv
// Buffers compute results in a FIFO and presents them through a single
// registered valid/ready output stage, counting downstream transfers.
module output_interface
   import output_interface_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int NUM_MODES      = DEF_NUM_MODES,
   parameter int RES_WIDTH      = DEF_RES_WIDTH,
   parameter int OUT_FIFO_DEPTH = DEF_OUT_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   res_valid,
   input  logic [DATA_WIDTH-1:0]  res__data,
   input  logic [NUM_MODES-1:0]   res__mode,
   input  logic [RES_WIDTH-1:0]   res__res,
   output logic                   res_ready,
   output logic                   out_pkt_valid,
   output logic [DATA_WIDTH-1:0]  out_pkt__data,
   output logic [NUM_MODES-1:0]   out_pkt__mode,
   output logic [RES_WIDTH-1:0]   out_pkt__res,
   input  logic                   out_pkt_ready,
   output logic [LEVEL_WIDTH-1:0] fifo_level,
   output logic [TX_WIDTH-1:0]    tx_count
);

   localparam int PKT_WIDTH = DATA_WIDTH + NUM_MODES + RES_WIDTH;
   localparam int LW        = $clog2(OUT_FIFO_DEPTH) + 1;

   logic [PKT_WIDTH-1:0] wr_pkt;
   logic [PKT_WIDTH-1:0] head_pkt;
   logic [PKT_WIDTH-1:0] out_q;
   logic [LW-1:0]        level;
   logic [TX_WIDTH-1:0]  tx_q;
   logic                 full;
   logic                 empty;
   logic                 load;
   logic                 xfer;

   assign wr_pkt    = {res__res, res__mode, res__data};
   assign res_ready = !full;
   assign load      = !empty && (!out_pkt_valid || out_pkt_ready);
   assign xfer      = out_pkt_valid && out_pkt_ready;

   output_fifo #(
      .WIDTH (PKT_WIDTH),
      .DEPTH (OUT_FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (res_valid),
      .wdata (wr_pkt),
      .pop   (load),
      .rdata (head_pkt),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_pkt_valid <= 1'b0;
         out_q         <= '0;
         tx_q          <= '0;
      end else begin
         if (load) begin
            out_q         <= head_pkt;
            out_pkt_valid <= 1'b1;
         end else if (xfer) begin
            out_pkt_valid <= 1'b0;
         end
         if (xfer) begin
            tx_q <= tx_q + 1'b1;
         end
      end
   end

   assign out_pkt__data = out_q[DATA_WIDTH-1:0];
   assign out_pkt__mode = out_q[DATA_WIDTH +: NUM_MODES];
   assign out_pkt__res  = out_q[DATA_WIDTH+NUM_MODES +: RES_WIDTH];
   assign fifo_level    = LEVEL_WIDTH'(level);
   assign tx_count      = tx_q;

endmodule

// File: tb/tb_output_interface.sv
// Directed vector table plus hand sequences for fill/drain, streaming,
// mid-stream reset and transfer-counter wrap.
module tb_output_interface;
   import output_interface_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        res_valid = 1'b0;
   logic [31:0] res__data = '0;
   logic [2:0]  res__mode = '0;
   logic [3:0]  res__res = '0;
   logic        res_ready;
   logic        out_pkt_valid;
   logic [31:0] out_pkt__data;
   logic [2:0]  out_pkt__mode;
   logic [3:0]  out_pkt__res;
   logic        out_pkt_ready = 1'b0;
   logic [3:0]  fifo_level;
   logic [15:0] tx_count;

   int total = 0;
   int bad   = 0;

   output_interface #(
      .DATA_WIDTH     (32),
      .NUM_MODES      (3),
      .RES_WIDTH      (4),
      .OUT_FIFO_DEPTH (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .res_valid     (res_valid),
      .res__data     (res__data),
      .res__mode     (res__mode),
      .res__res      (res__res),
      .res_ready     (res_ready),
      .out_pkt_valid (out_pkt_valid),
      .out_pkt__data (out_pkt__data),
      .out_pkt__mode (out_pkt__mode),
      .out_pkt__res  (out_pkt__res),
      .out_pkt_ready (out_pkt_ready),
      .fifo_level    (fifo_level),
      .tx_count      (tx_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] d;
      logic [2:0]  m;
      logic [3:0]  r;
      logic        ordy;
      logic        e_rr;
      logic        e_ov;
      logic [31:0] e_d;
      logic [2:0]  e_m;
      logic [3:0]  e_r;
      logic [3:0]  e_lvl;
      logic [15:0] e_tx;
      logic        cf;
   } vec_t;

   vec_t vecs[12];
   pkt_t q[$];
   pkt_t front;
   logic [15:0] wrap_exp[3];

   initial begin
      int acc;
      int xfers;

      //           rst   rv    data          m     r      ordy  rr    ov    e_data        e_m   e_r    lvl    tx      cf
      vecs[0]  = '{1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  4'd0, 16'd0, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 32'hDEADBEEF, 3'd2, 4'h5,  1'b1, 1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  4'd1, 16'd0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        3'd0, 4'h0,  1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 3'd2, 4'h5,  4'd0, 16'd0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,        3'd0, 4'h0,  1'b1, 1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  4'd0, 16'd1, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'h11111111, 3'd1, 4'h3,  1'b0, 1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  4'd1, 16'd1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h22222222, 3'd7, 4'hF,  1'b0, 1'b1, 1'b1, 32'h11111111, 3'd1, 4'h3,  4'd1, 16'd1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,        3'd0, 4'h0,  1'b0, 1'b1, 1'b1, 32'h11111111, 3'd1, 4'h3,  4'd1, 16'd1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,        3'd0, 4'h0,  1'b1, 1'b1, 1'b1, 32'h22222222, 3'd7, 4'hF,  4'd0, 16'd2, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 32'h33333333, 3'd0, 4'h0,  1'b1, 1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  4'd1, 16'd3, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        3'd0, 4'h0,  1'b0, 1'b1, 1'b1, 32'h33333333, 3'd0, 4'h0,  4'd0, 16'd3, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 32'h44444444, 3'd6, 4'h6,  1'b1, 1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  4'd0, 16'd0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 32'h0,        3'd0, 4'h0,  1'b1, 1'b1, 1'b0, 32'h0,        3'd0, 4'h0,  4'd0, 16'd0, 1'b0};
      wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001};

      // Directed table: inputs applied for one edge, outputs sampled at the next falling edge
      for (int i = 0; i < 12; i++) begin
         rst = vecs[i].rst; res_valid = vecs[i].rv; res__data = vecs[i].d;
         res__mode = vecs[i].m; res__res = vecs[i].r; out_pkt_ready = vecs[i].ordy;
         @(negedge clk);
         chk($sformatf("v%0d.res_ready", i), 32'(res_ready), 32'(vecs[i].e_rr));
         chk($sformatf("v%0d.valid", i), 32'(out_pkt_valid), 32'(vecs[i].e_ov));
         chk($sformatf("v%0d.level", i), 32'(fifo_level), 32'(vecs[i].e_lvl));
         chk($sformatf("v%0d.tx_count", i), 32'(tx_count), 32'(vecs[i].e_tx));
         if (vecs[i].cf) begin
            chk($sformatf("v%0d.data", i), out_pkt__data, vecs[i].e_d);
            chk($sformatf("v%0d.mode", i), 32'(out_pkt__mode), 32'(vecs[i].e_m));
            chk($sformatf("v%0d.res", i), 32'(out_pkt__res), 32'(vecs[i].e_r));
         end
      end

      // Backpressure fill: 10 offered, 9 accepted, head held stable
      rst = 1'b1; res_valid = 1'b0; out_pkt_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         logic [3:0] el;
         chk($sformatf("fill%0d.res_ready", i), 32'(res_ready), (i < 9) ? 32'd1 : 32'd0);
         res_valid = 1'b1; res__data = 32'h100 + i; res__mode = i[2:0]; res__res = i[3:0];
         @(negedge clk);
         el = (i == 0) ? 4'd1 : ((i > 8) ? 4'd8 : 4'(i));
         chk($sformatf("fill%0d.level", i), 32'(fifo_level), 32'(el));
         chk($sformatf("fill%0d.valid", i), 32'(out_pkt_valid), (i >= 1) ? 32'd1 : 32'd0);
         if (i >= 1) begin
            chk($sformatf("fill%0d.data", i), out_pkt__data, 32'h100);
            chk($sformatf("fill%0d.mode", i), 32'(out_pkt__mode), 32'd0);
            chk($sformatf("fill%0d.res", i), 32'(out_pkt__res), 32'd0);
         end
      end
      res_valid = 1'b0;
      @(negedge clk);
      chk("full.res_ready", 32'(res_ready), 32'd0);
      chk("full.level", 32'(fifo_level), 32'd8);
      chk("full.data", out_pkt__data, 32'h100);

      // Drain: res_ready must not react combinationally to out_pkt_ready
      out_pkt_ready = 1'b1;
      #1;
      chk("drain.res_ready_comb", 32'(res_ready), 32'd0);
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         chk($sformatf("drain%0d.res_ready", j), 32'(res_ready), 32'd1);
         chk($sformatf("drain%0d.level", j), 32'(fifo_level), (j <= 8) ? 32'(8 - j) : 32'd0);
         chk($sformatf("drain%0d.valid", j), 32'(out_pkt_valid), (j <= 8) ? 32'd1 : 32'd0);
         chk($sformatf("drain%0d.tx_count", j), 32'(tx_count), 32'(j));
         if (j <= 8) begin
            chk($sformatf("drain%0d.data", j), out_pkt__data, 32'h100 + j);
            chk($sformatf("drain%0d.mode", j), 32'(out_pkt__mode), 32'(j % 8));
            chk($sformatf("drain%0d.res", j), 32'(out_pkt__res), 32'(j));
         end
      end

      // Streaming with scoreboard
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_pkt_ready = 1'b1;
      acc = 0; xfers = 0;
      q.delete();
      for (int c = 0; c < 104; c++) begin
         if (out_pkt_valid) begin
            if (q.size() == 0) begin
               chk("stream.unexpected_pkt", out_pkt__data, 32'hFFFFFFFF);
            end else begin
               front = q.pop_front();
               chk("stream.data", out_pkt__data, front.data);
               chk("stream.mode", 32'(out_pkt__mode), 32'(front.mode));
               chk("stream.res", 32'(out_pkt__res), 32'(front.res));
               xfers++;
            end
         end
         chk("stream.level_le1", 32'(fifo_level <= 4'd1), 32'd1);
         if (c < 100) begin
            res_valid = 1'b1; res__data = 32'(c) * 32'd3 + 32'd7;
            res__mode = 3'(c); res__res = 4'(c + 5);
            if (res_ready) begin
               q.push_back('{res: res__res, mode: res__mode, data: res__data});
               acc++;
            end
         end else begin
            res_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("stream.accepted", 32'(acc), 32'd100);
      chk("stream.transfers", 32'(xfers), 32'd100);
      chk("stream.tx_count", 32'(tx_count), 32'd100);
      chk("stream.leftover", 32'(q.size()), 32'd0);

      // Reset with five packets buffered
      out_pkt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         res_valid = 1'b1; res__data = 32'hA0 + i; res__mode = 3'd1; res__res = 4'd2;
         @(negedge clk);
      end
      res_valid = 1'b0;
      chk("midrst.pre_valid", 32'(out_pkt_valid), 32'd1);
      chk("midrst.pre_level", 32'(fifo_level), 32'd4);
      chk("midrst.pre_data", out_pkt__data, 32'hA0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst.valid", 32'(out_pkt_valid), 32'd0);
      chk("midrst.level", 32'(fifo_level), 32'd0);
      chk("midrst.tx_count", 32'(tx_count), 32'd0);
      chk("midrst.res_ready", 32'(res_ready), 32'd1);
      chk("midrst.data", out_pkt__data, 32'd0);
      out_pkt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("midrst.ghost%0d", i), 32'(out_pkt_valid), 32'd0);
      end
      res_valid = 1'b1; res__data = 32'hBEEF0001; res__mode = 3'd5; res__res = 4'd9;
      @(negedge clk);
      res_valid = 1'b0;
      chk("post.valid_n1", 32'(out_pkt_valid), 32'd0);
      chk("post.level_n1", 32'(fifo_level), 32'd1);
      @(negedge clk);
      chk("post.valid_n2", 32'(out_pkt_valid), 32'd1);
      chk("post.data", out_pkt__data, 32'hBEEF0001);
      chk("post.mode", 32'(out_pkt__mode), 32'd5);
      chk("post.res", 32'(out_pkt__res), 32'd9);
      @(negedge clk);
      chk("post.tx_count", 32'(tx_count), 32'd1);

      // Counter wrap: 0xFFFE real transfers, then three more one at a time
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_pkt_ready = 1'b1; res_valid = 1'b1; res__data = 32'h5A5A0000;
      for (int c = 0; c < 65534; c++) begin
         @(negedge clk);
      end
      res_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wrap.preload", 32'(tx_count), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         res_valid = 1'b1; res__data = 32'hC0 + k;
         @(negedge clk);
         res_valid = 1'b0;
         repeat (2) @(negedge clk);
         chk($sformatf("wrap.step%0d", k), 32'(tx_count), 32'(wrap_exp[k]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/output_interface.md
OUTPUT_INTERFACE -- requirements
Module: output_interface

Interface
REQ-001 Parameter DATA_WIDTH, 32, result data width.
REQ-002 Parameter NUM_MODES, 3, mode field width.
REQ-003 Parameter RES_WIDTH, 4, result tag field width.
REQ-004 Parameter OUT_FIFO_DEPTH, 8, result FIFO entries (power of two).
REQ-005 The port list SHALL be exactly as follows; one clock; reset is synchronous and active-high.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- res_valid  input  1  compute core offers a result.
- res__data  input  DATA_WIDTH  result value.
- res__mode  input  NUM_MODES  mode of the originating op packet.
- res__res  input  RES_WIDTH  resolution/tag of the originating op packet.
- res_ready  output  1  block can accept a result.
- out_pkt_valid  output  1  result packet presented downstream.
- out_pkt__data  output  DATA_WIDTH  packet data.
- out_pkt__mode  output  NUM_MODES  packet mode.
- out_pkt__res  output  RES_WIDTH  packet tag.
- out_pkt_ready  input  1  downstream accepts the packet.
- fifo_level  output  4  FIFO occupancy, 0..OUT_FIFO_DEPTH.
- tx_count  output  16  packets transferred downstream.

Function
REQ-006 A result SHALL be accepted in any cycle where res_valid && res_ready; the packet {res__res, res__mode, res__data} SHALL be written to the FIFO tail.
REQ-007 res_ready SHALL equal !fifo_full, decided from registered state only; no combinational path from out_pkt_ready to res_ready.
REQ-008 At full, a same-cycle pop SHALL NOT permit a same-cycle push; res_ready rises the cycle after the pop.
REQ-009 The output register SHALL load the FIFO head, and pop it, in any cycle where !fifo_empty && (!out_pkt_valid || out_pkt_ready).
REQ-010 A transfer SHALL occur when out_pkt_valid && out_pkt_ready; out_pkt_valid SHALL clear after a transfer unless a new load occurs in the same cycle.
REQ-011 While out_pkt_valid && !out_pkt_ready, all out_pkt__* fields SHALL hold stable.
REQ-012 Latency SHALL be 2 cycles: a result accepted in cycle N into an empty block appears with out_pkt_valid high in cycle N+2.
REQ-013 With out_pkt_ready held high, throughput SHALL be one packet per cycle.
REQ-014 Packets SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-015 Simultaneous push and pop with the FIFO neither empty nor full SHALL leave fifo_level unchanged.
REQ-016 Read and write pointers SHALL wrap modulo OUT_FIFO_DEPTH.
REQ-017 A pop on an empty FIFO and a push on a full FIFO SHALL be impossible by construction.
REQ-018 fifo_level SHALL be registered and count FIFO entries only, excluding the output register.
REQ-019 tx_count SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.

Reset
REQ-020 While rst is high at a clk edge, the block SHALL clear FIFO pointers and output register state.
REQ-021 Reset SHALL produce out_pkt_valid=0, res_ready=1, fifo_level=0, tx_count=0 and out_pkt__* = 0.
REQ-022 Reset mid-operation SHALL discard all buffered and presented packets; the first post-reset result obeys REQ-012.

Structure
REQ-023 DATA_WIDTH, NUM_MODES, RES_WIDTH, OUT_FIFO_DEPTH and the packet width (DATA_WIDTH+NUM_MODES+RES_WIDTH=39) SHALL live in the shared param.vh.
REQ-024 Packet field order SHALL be {res, mode, data}, data in the LSBs, matching the input-side op packet.
REQ-025 Storage SHALL be one sub-module, output_fifo: synchronous, active-high reset, with full, empty and level outputs.

Verification
REQ-026 Single result: data=0xDEADBEEF, mode=3'b010, res=4'h5 accepted at cycle 10, out_pkt_ready=1 -> out_pkt_valid high at cycle 12 with the same fields; tx_count=1.
REQ-027 Backpressure fill: out_pkt_ready=0, push 10 results -> 9 accepted (8 in FIFO, 1 in output register), res_ready=0, fifo_level=8; out_pkt__* stable throughout.
REQ-028 Drain from full: raise out_pkt_ready -> 9 packets in order at one per cycle; res_ready returns the cycle after the first pop; fifo_level reaches 0.
REQ-029 Streaming: res_valid=1 and out_pkt_ready=1 for 100 cycles with incrementing data -> 100 in-order transfers, fifo_level never exceeds 1, tx_count=100.
REQ-030 Reset mid-stream: assert rst for 1 cycle with 5 packets buffered -> out_pkt_valid=0, fifo_level=0, tx_count=0 next cycle; the buffered packets never appear.
REQ-031 Counter wrap: preload 0xFFFE transfers (force/backdoor), then transfer 3 packets -> tx_count shows 0xFFFF, then 0x0000, then 0x0001.
